// File: rtl/adc_scan_scheduler.sv
// Scan/override scheduler for a pipelined single-frame SPI ADC engine.
// Results arrive one frame late and are retagged with the previous frame's channel.
module adc_scan_scheduler #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [7:0]  ch_enable,
  input  logic        ovr_req,
  input  logic [2:0]  ovr_ch,
  output logic        ovr_ack,
  output logic        frm_start,
  output logic [2:0]  frm_addr,
  input  logic        frm_busy,
  input  logic        frm_done,
  input  logic [11:0] frm_data,
  output logic        res_valid,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        res_ovr,
  output logic        scan_busy,
  output logic        scan_done,
  output logic        scan_overrun,
  output logic        err_timeout,
  input  logic        err_clr
);
  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_POST} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [TMO_W-1:0] r_tmo;
  logic             r_scan_pending;
  logic [7:0]       r_rem;
  logic             r_cur_ovr, r_cur_flush, r_cur_last;
  logic [2:0]       r_prev_ch;
  logic             r_prev_ovr, r_prev_valid, r_prev_last;
  logic             r_ovr_sent;
  logic             r_ovr_ack, r_frm_start, r_res_valid, r_res_ovr;
  logic [2:0]       r_frm_addr, r_res_ch;
  logic [11:0]      r_res_data;
  logic             r_scan_busy, r_scan_done, r_scan_overrun, r_err_timeout;

  logic             w_ovr_go, w_take_scan;
  logic [7:0]       w_src, w_src_rest;
  logic [2:0]       w_scan_ch;

  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // In IDLE the candidate mask is the live ch_enable (latched on scan start), otherwise the remaining scan set.
  always_comb begin
    w_ovr_go    = ovr_req && !r_ovr_sent;
    w_src       = (r_state == S_IDLE) ? ch_enable : r_rem;
    w_scan_ch   = f_lowest(w_src);
    w_src_rest  = w_src & ~(8'b1 << w_scan_ch);
    w_take_scan = (r_state == S_IDLE) && !w_ovr_go && r_scan_pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_div          <= '0;
      r_tmo          <= '0;
      r_scan_pending <= 1'b0;
      r_rem          <= '0;
      r_cur_ovr      <= 1'b0;
      r_cur_flush    <= 1'b0;
      r_cur_last     <= 1'b0;
      r_prev_ch      <= '0;
      r_prev_ovr     <= 1'b0;
      r_prev_valid   <= 1'b0;
      r_prev_last    <= 1'b0;
      r_ovr_sent     <= 1'b0;
      r_ovr_ack      <= 1'b0;
      r_frm_start    <= 1'b0;
      r_frm_addr     <= '0;
      r_res_valid    <= 1'b0;
      r_res_ch       <= '0;
      r_res_data     <= '0;
      r_res_ovr      <= 1'b0;
      r_scan_busy    <= 1'b0;
      r_scan_done    <= 1'b0;
      r_scan_overrun <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_frm_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_ovr   <= 1'b0;
      r_ovr_ack   <= 1'b0;
      r_scan_done <= 1'b0;
      if (err_clr) begin
        r_scan_overrun <= 1'b0;
        r_err_timeout  <= 1'b0;
      end
      // Re-arm one cycle after the ack so a still-high ovr_req is not reissued.
      if (r_ovr_ack) r_ovr_sent <= 1'b0;

      case (r_state)
        S_IDLE, S_POST: begin
          if (w_ovr_go) begin
            r_frm_addr  <= ovr_ch;
            r_cur_ovr   <= 1'b1;
            r_cur_flush <= 1'b0;
            r_cur_last  <= 1'b0;
            r_ovr_sent  <= 1'b1;
            r_state     <= S_ISSUE;
          end else if (r_state == S_POST && r_rem != '0) begin
            r_frm_addr  <= w_scan_ch;
            r_rem       <= w_src_rest;
            r_cur_ovr   <= 1'b0;
            r_cur_flush <= 1'b0;
            r_cur_last  <= (w_src_rest == '0);
            r_state     <= S_ISSUE;
          end else if (r_state == S_POST && r_prev_valid) begin
            r_frm_addr  <= r_prev_ch;
            r_cur_ovr   <= 1'b0;
            r_cur_flush <= 1'b1;
            r_cur_last  <= 1'b0;
            r_state     <= S_ISSUE;
          end else if (w_take_scan) begin
            r_scan_pending <= 1'b0;
            if (ch_enable == '0) begin
              r_scan_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_scan_busy <= 1'b1;
              r_frm_addr  <= w_scan_ch;
              r_rem       <= w_src_rest;
              r_cur_ovr   <= 1'b0;
              r_cur_flush <= 1'b0;
              r_cur_last  <= (w_src_rest == '0);
              r_state     <= S_ISSUE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (!frm_busy) begin
            r_frm_start <= 1'b1;
            r_tmo       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frm_done) begin
            if (r_prev_valid) begin
              r_res_valid <= 1'b1;
              r_res_ch    <= r_prev_ch;
              r_res_data  <= frm_data;
              r_res_ovr   <= r_prev_ovr;
              r_ovr_ack   <= r_prev_ovr;
              if (r_prev_last) begin
                r_scan_done <= 1'b1;
                r_scan_busy <= 1'b0;
              end
            end
            r_prev_ch    <= r_frm_addr;
            r_prev_ovr   <= r_cur_ovr;
            r_prev_last  <= r_cur_last;
            r_prev_valid <= !r_cur_flush;
            r_state      <= S_POST;
          end else if (r_tmo == TMO_LAST) begin
            // Abort the scan; an unacked override is re-sent from IDLE.
            r_err_timeout <= 1'b1;
            r_prev_valid  <= 1'b0;
            r_scan_busy   <= 1'b0;
            r_rem         <= '0;
            r_ovr_sent    <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (!scan_en) begin
        r_div <= '0;
      end else if (r_div == DIV_LAST) begin
        r_div          <= '0;
        r_scan_pending <= 1'b1;
        if (r_scan_pending && !w_take_scan) r_scan_overrun <= 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign ovr_ack      = r_ovr_ack;
  assign frm_start    = r_frm_start;
  assign frm_addr     = r_frm_addr;
  assign res_valid    = r_res_valid;
  assign res_ch       = r_res_ch;
  assign res_data     = r_res_data;
  assign res_ovr      = r_res_ovr;
  assign scan_busy    = r_scan_busy;
  assign scan_done    = r_scan_done;
  assign scan_overrun = r_scan_overrun;
  assign err_timeout  = r_err_timeout;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a pipelined SPI frame engine model.
module tb_adc_scan_scheduler;
  localparam int unsigned SCAN_DIV = 64;
  localparam int unsigned TMO      = 100;

  logic        clk = 1'b0;
  logic        rst, scan_en, ovr_req, frm_busy, frm_done, err_clr;
  logic [7:0]  ch_enable;
  logic [2:0]  ovr_ch, frm_addr, res_ch;
  logic [11:0] frm_data, res_data;
  logic        ovr_ack, frm_start, res_valid, res_ovr;
  logic        scan_busy, scan_done, scan_overrun, err_timeout;
  logic [25:0] w_outs;

  always #5 clk = ~clk;

  adc_scan_scheduler #(.SCAN_DIV(SCAN_DIV), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .ch_enable(ch_enable),
    .ovr_req(ovr_req), .ovr_ch(ovr_ch), .ovr_ack(ovr_ack),
    .frm_start(frm_start), .frm_addr(frm_addr), .frm_busy(frm_busy),
    .frm_done(frm_done), .frm_data(frm_data),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data), .res_ovr(res_ovr),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_overrun(scan_overrun),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  assign w_outs = {ovr_ack, frm_start, frm_addr, res_valid, res_ch, res_data,
                   res_ovr, scan_busy, scan_done, scan_overrun, err_timeout};

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame engine: returns 0x100 + address of the previous frame after eng_lat cycles.
  int unsigned eng_lat = 3;
  logic        withhold = 1'b0;
  initial begin
    int unsigned cnt;
    logic [2:0]  cur, prev;
    logic        dead;
    cnt = 0; cur = '0; prev = '0; dead = 1'b0;
    frm_busy = 1'b0; frm_done = 1'b0; frm_data = '0;
    forever begin
      @(posedge clk); #1;
      frm_done = 1'b0;
      if (frm_start) begin
        frm_busy = 1'b1; cnt = eng_lat; cur = frm_addr; dead = withhold;
      end else if (frm_busy) begin
        if (dead) begin
          if (!withhold) begin frm_busy = 1'b0; dead = 1'b0; end
        end else begin
          cnt--;
          if (cnt == 0) begin
            frm_busy = 1'b0; frm_done = 1'b1;
            frm_data = 12'h100 + {9'b0, prev};
            prev = cur;
          end
        end
      end
    end
  end

  logic [2:0]  addr_q[$];
  int unsigned st_q[$], dn_q[$];
  logic [15:0] res_q[$];
  int          sd_cnt = 0, sd_resn = 0, ack_cnt = 0;
  int unsigned sd_cyc = 0, ack_cyc = 0;
  logic        sd_rv = 1'b0, ack_rv = 1'b0;
  always @(negedge clk) begin
    if (frm_start) begin addr_q.push_back(frm_addr); st_q.push_back(cyc); end
    if (frm_done) dn_q.push_back(cyc);
    if (res_valid) res_q.push_back({res_ovr, res_ch, res_data});
    if (scan_done) begin sd_cnt++; sd_cyc = cyc; sd_resn = res_q.size(); sd_rv = res_valid; end
    if (ovr_ack) begin ack_cnt++; ack_cyc = cyc; ack_rv = res_valid; end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  int b_addr, b_res, b_dn, b_sd, b_ack;
  task automatic snap();
    b_addr = addr_q.size(); b_res = res_q.size(); b_dn = dn_q.size();
    b_sd = sd_cnt; b_ack = ack_cnt;
  endtask

  task automatic tick();
    @(negedge clk); #1;
    if (ovr_ack) ovr_req = 1'b0;
  endtask

  task automatic settle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic trigger(input logic [7:0] m, output int unsigned t0);
    int unsigned n;
    ch_enable = m; scan_en = 1'b1; t0 = cyc; n = 0;
    while (addr_q.size() == b_addr && sd_cnt == b_sd && n < SCAN_DIV + 20) begin
      tick(); n++;
    end
    scan_en = 1'b0;
    check_eq("trigger_seen", 32'(n < SCAN_DIV + 20), 1);
  endtask

  task automatic wait_sd(input int target, input int unsigned bound);
    int unsigned n;
    n = 0;
    while (sd_cnt < target && n < bound) begin tick(); n++; end
    check_eq("scan_done_seen", 32'(n < bound), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, n, s;
    logic [2:0]  exp_a[6];
    logic [15:0] exp_r[5];
    rst = 1'b1; scan_en = 1'b0; ch_enable = '0; ovr_req = 1'b0; ovr_ch = '0; err_clr = 1'b0;
    settle(3);
    check_eq("reset_outputs", 32'(w_outs), 0);
    rst = 1'b0;
    settle(2);

    // Two-channel scan: addresses 0,1,1(flush), results ch0/ch1.
    snap(); trigger(8'h03, t0); wait_sd(b_sd + 1, 400); settle(20);
    check_eq("t1_nfrm", addr_q.size() - b_addr, 3);
    check_eq("t1_a0", 32'(addr_q[b_addr]), 0);
    check_eq("t1_a1", 32'(addr_q[b_addr+1]), 1);
    check_eq("t1_a2", 32'(addr_q[b_addr+2]), 1);
    check_eq("t1_first_start_lat", st_q[b_addr] - t0, SCAN_DIV + 2);
    check_eq("t1_nres", res_q.size() - b_res, 2);
    check_eq("t1_r0", 32'(res_q[b_res]), {16'h0, 1'b0, 3'd0, 12'h100});
    check_eq("t1_r1", 32'(res_q[b_res+1]), {16'h0, 1'b0, 3'd1, 12'h101});
    check_eq("t1_sd_after_res", sd_resn - b_res, 2);
    check_eq("t1_sd_with_rv", 32'(sd_rv), 1);
    check_eq("t1_busy_low", 32'(scan_busy), 0);
    check_eq("t1_no_ack", ack_cnt - b_ack, 0);

    // Empty mask: scan_done one cycle after the trigger, no frames.
    snap(); trigger(8'h00, t0); settle(10);
    check_eq("t2_sd_cnt", sd_cnt - b_sd, 1);
    check_eq("t2_sd_lat", sd_cyc - t0, SCAN_DIV + 1);
    check_eq("t2_nfrm", addr_q.size() - b_addr, 0);
    check_eq("t2_nres", res_q.size() - b_res, 0);

    // Idle override to ch5: two frames, one tagged result.
    snap(); ovr_ch = 3'd5; ovr_req = 1'b1; n = 0;
    while (ack_cnt == b_ack && n < 100) begin tick(); n++; end
    check_eq("t3_ack_seen", 32'(n < 100), 1);
    settle(20);
    check_eq("t3_nfrm", addr_q.size() - b_addr, 2);
    check_eq("t3_a0", 32'(addr_q[b_addr]), 5);
    check_eq("t3_a1", 32'(addr_q[b_addr+1]), 5);
    check_eq("t3_nres", res_q.size() - b_res, 1);
    check_eq("t3_r0", 32'(res_q[b_res]), {16'h0, 1'b1, 3'd5, 12'h105});
    check_eq("t3_ack_cnt", ack_cnt - b_ack, 1);
    check_eq("t3_ack_lat", ack_cyc - dn_q[b_dn+1], 1);
    check_eq("t3_ack_with_rv", 32'(ack_rv), 1);
    check_eq("t3_no_sd", sd_cnt - b_sd, 0);

    // Override inserted mid-scan during the ch1 frame.
    exp_a = '{3'd0, 3'd1, 3'd6, 3'd2, 3'd3, 3'd3};
    exp_r = '{16'h0100, 16'h1101, 16'hE106, 16'h2102, 16'h3103};
    snap(); trigger(8'h0F, t0); n = 0;
    while (addr_q.size() - b_addr < 2 && n < 50) begin tick(); n++; end
    ovr_ch = 3'd6; ovr_req = 1'b1;
    wait_sd(b_sd + 1, 600); settle(20);
    check_eq("t4_nfrm", addr_q.size() - b_addr, 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t4_a%0d", i), 32'(addr_q[b_addr+i]), 32'(exp_a[i]));
    check_eq("t4_nres", res_q.size() - b_res, 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t4_r%0d", i), 32'(res_q[b_res+i]), 32'(exp_r[i]));
    check_eq("t4_ack_cnt", ack_cnt - b_ack, 1);

    // Withheld frm_done: timeout exactly TMO cycles after frm_start.
    snap(); withhold = 1'b1; trigger(8'h01, t0);
    s = st_q[b_addr]; n = 0;
    while (!err_timeout && n < TMO + 20) begin tick(); n++; end
    check_eq("t5_tmo_lat", cyc - s, TMO);
    check_eq("t5_busy_low", 32'(scan_busy), 0);
    check_eq("t5_nres", res_q.size() - b_res, 0);
    withhold = 1'b0; settle(5);
    snap(); trigger(8'h01, t0); wait_sd(b_sd + 1, 300); settle(20);
    check_eq("t5b_nfrm", addr_q.size() - b_addr, 2);
    check_eq("t5b_nres", res_q.size() - b_res, 1);
    check_eq("t5b_r0", 32'(res_q[b_res]), {16'h0, 1'b0, 3'd0, 12'h100});
    check_eq("t5_err_sticky", 32'(err_timeout), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    check_eq("t5_err_cleared", 32'(err_timeout), 0);

    // Slow engine: scan outlasts two periods, exactly one queued scan follows.
    eng_lat = 50;
    snap(); ch_enable = 8'h0F; scan_en = 1'b1; n = 0;
    while (!scan_overrun && n < 400) begin tick(); n++; end
    scan_en = 1'b0;
    check_eq("t6_overrun", 32'(scan_overrun), 1);
    wait_sd(b_sd + 2, 1500); settle(150);
    check_eq("t6_sd_cnt", sd_cnt - b_sd, 2);
    check_eq("t6_nfrm", addr_q.size() - b_addr, 10);
    check_eq("t6_nres", res_q.size() - b_res, 8);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    check_eq("t6_overrun_cleared", 32'(scan_overrun), 0);

    // Reset while waiting on a frame.
    snap(); ovr_ch = 3'd2; ovr_req = 1'b1; n = 0;
    while (addr_q.size() == b_addr && n < 20) begin tick(); n++; end
    settle(5);
    check_eq("t7_in_frame", 32'(frm_busy), 1);
    rst = 1'b1; tick();
    check_eq("t7_reset_outputs", 32'(w_outs), 0);
    ovr_req = 1'b0; rst = 1'b0; settle(5);
    check_eq("t7_idle_outputs", 32'(w_outs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
